// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the framebuffer blocks.
//   - Default geometry constants, shared by the framebuffer writer and scanout.
//   - fb_state_e: scanout FSM encoding (IDLE=0, RUN=1).
//   - fb_ppw(): pixels per RAM word for a given word/pixel width.
package fb_pkg;

    localparam int FB_ADDR_WIDTH = 8;
    localparam int FB_DATA_WIDTH = 8;
    localparam int FB_PIX_WIDTH  = 1;
    localparam int FB_LINE_PIX   = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fb_state_e;

    function automatic int fb_ppw(input int data_width, input int pix_width);
        return data_width / pix_width;
    endfunction

endpackage

// File: rtl/fb_prefetch.sv
// fb_prefetch: two-entry word buffer in front of the framebuffer RAM read port.
//   Tracks one outstanding read through the RAM's registered read latency and
//   lands returning words into cur (being unpacked) or nxt (prefetched).
// Ports:
//   clk, reset    : clock, synchronous active-high reset (empties both entries,
//                   drops any read still in flight)
//   issue         : in,  a read address is launched on this edge
//   pop_word      : in,  the last pixel of cur is consumed on this edge
//   rd_data       : in,  RAM read data
//   can_issue     : out, a read launched now is guaranteed a landing slot
//   load          : out, rd_data carries a requested word this cycle
//   cur_word      : out, word being unpacked
//   cur_valid     : out, cur_word holds a word
module fb_prefetch
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue,
    input  logic                  pop_word,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  can_issue,
    output logic                  load,
    output logic [DATA_WIDTH-1:0] cur_word,
    output logic                  cur_valid
);

    logic [DATA_WIDTH-1:0] cur_q, cur_d;
    logic [DATA_WIDTH-1:0] nxt_q, nxt_d;
    logic                  cur_valid_q, cur_valid_d;
    logic                  nxt_valid_q, nxt_valid_d;
    // inflight_q: address is on the RAM port this cycle, data arrives next cycle.
    // rvalid_q:   that data is on rd_data this cycle.
    logic                  inflight_q, inflight_d;
    logic                  rvalid_q, rvalid_d;
    logic                  pop_ok;
    logic [1:0]            occ_after;

    always_comb begin
        pop_ok = pop_word && cur_valid_q;
        // Occupancy once this edge's pop and landing are applied. A read issued
        // now lands two edges later, and nothing else can land in between
        // because inflight blocks back-to-back issues.
        occ_after = {1'b0, cur_valid_q} + {1'b0, nxt_valid_q}
                  - {1'b0, pop_ok} + {1'b0, rvalid_q};
        can_issue = !inflight_q && (occ_after < 2'd2);

        cur_d       = cur_q;
        nxt_d       = nxt_q;
        cur_valid_d = cur_valid_q;
        nxt_valid_d = nxt_valid_q;
        inflight_d  = issue;
        rvalid_d    = inflight_q;

        if (pop_ok) begin
            cur_d       = nxt_q;
            cur_valid_d = nxt_valid_q;
            nxt_valid_d = 1'b0;
        end

        if (rvalid_q) begin
            if (!cur_valid_q || (pop_ok && !nxt_valid_q)) begin
                cur_d       = rd_data;
                cur_valid_d = 1'b1;
            end else begin
                nxt_d       = rd_data;
                nxt_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q       <= '0;
            nxt_q       <= '0;
            cur_valid_q <= 1'b0;
            nxt_valid_q <= 1'b0;
            inflight_q  <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            cur_valid_q <= cur_valid_d;
            nxt_valid_q <= nxt_valid_d;
            inflight_q  <= inflight_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign load      = rvalid_q;
    assign cur_word  = cur_q;
    assign cur_valid = cur_valid_q;

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: framebuffer scanout engine on the RAM read port.
//   On start, reads words 0..FRAME_WORDS-1 and emits their pixels LSB-first
//   with end-of-line / end-of-frame markers.
// Ports:
//   clk, reset   : clock (RAM rd_clk tied to it), synchronous active-high reset
//   start        : in,  one-cycle frame request, ignored while busy
//   busy         : out, frame in progress (falls the cycle after the eof handshake)
//   done         : out, one-cycle pulse the cycle after the eof handshake
//   rd_addr      : out, registered RAM read address
//   rd_data      : in,  RAM data, valid the cycle after rd_addr
//   out_valid/out_ready/out_pixel/out_eol/out_eof : pixel stream
//   dbg_state    : out, current FSM state
// Stream handshake: a pixel transfers on a rising edge where out_valid &&
// out_ready. Once out_valid is high, out_pixel/out_eol/out_eof stay stable
// until that transfer happens; out_valid never drops without a transfer
// except on reset.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = FB_DATA_WIDTH,
    parameter int PIX_WIDTH   = FB_PIX_WIDTH,
    parameter int FRAME_WORDS = 1 << ADDR_WIDTH,
    parameter int LINE_PIX    = FB_LINE_PIX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PIX_WIDTH-1:0]  out_pixel,
    output logic                  out_eol,
    output logic                  out_eof,
    output fb_state_e             dbg_state
);

    localparam int PPW       = fb_ppw(DATA_WIDTH, PIX_WIDTH);
    localparam int PIX_IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int X_W       = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [PIX_IDX_W-1:0]  LAST_PIX  = PIX_IDX_W'(PPW - 1);
    localparam logic [X_W-1:0]        LAST_X    = X_W'(LINE_PIX - 1);

    if (PPW < 2 || PPW * PIX_WIDTH != DATA_WIDTH) begin : g_bad_ppw
        $error("fb_scanout: DATA_WIDTH/PIX_WIDTH must be an integer >= 2");
    end
    if (FRAME_WORDS < 1 || FRAME_WORDS > (1 << ADDR_WIDTH)) begin : g_bad_frame
        $error("fb_scanout: FRAME_WORDS out of range for ADDR_WIDTH");
    end
    if ((FRAME_WORDS * PPW) % LINE_PIX != 0) begin : g_bad_line
        $error("fb_scanout: frame pixel count must be a multiple of LINE_PIX");
    end

    fb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [PIX_IDX_W-1:0]  pix_idx_q, pix_idx_d;
    logic [X_W-1:0]        x_q, x_d;
    logic                  done_q, done_d;

    logic                  can_issue;
    logic                  load;
    logic [DATA_WIDTH-1:0] cur_word;
    logic                  cur_valid;
    logic                  issue;
    logic                  pop_word;
    logic                  valid_int;
    logic                  hs;
    logic                  last_pix;
    logic                  eof_pix;
    logic                  run_issue;
    logic [PIX_WIDTH-1:0]  pixel_sel;

    fb_prefetch #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_prefetch (
        .clk       (clk),
        .reset     (reset),
        .issue     (issue),
        .pop_word  (pop_word),
        .rd_data   (rd_data),
        .can_issue (can_issue),
        .load      (load),
        .cur_word  (cur_word),
        .cur_valid (cur_valid)
    );

    always_comb begin
        valid_int = (state_q == ST_RUN) && cur_valid;
        hs        = valid_int && out_ready;
        last_pix  = (pix_idx_q == LAST_PIX);
        eof_pix   = (word_cnt_q == LAST_WORD) && last_pix;
        pop_word  = hs && last_pix;
        // rd_addr_q is the last address issued; more words remain until it
        // reaches LAST_WORD, where it then holds after the frame.
        run_issue = (state_q == ST_RUN) && (rd_addr_q != LAST_WORD) && can_issue;
        issue     = ((state_q == ST_IDLE) && start) || run_issue;

        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        word_cnt_d = word_cnt_q;
        pix_idx_d  = pix_idx_q;
        x_d        = x_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Word 0 is requested on the accepting edge itself.
                    state_d    = ST_RUN;
                    rd_addr_d  = '0;
                    word_cnt_d = '0;
                    pix_idx_d  = '0;
                    x_d        = '0;
                end
            end
            ST_RUN: begin
                if (run_issue) begin
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                end
                if (hs) begin
                    x_d       = (x_q == LAST_X) ? '0 : x_q + X_W'(1);
                    pix_idx_d = last_pix ? '0 : pix_idx_q + PIX_IDX_W'(1);
                    if (last_pix && !eof_pix) begin
                        word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
                    end
                    if (eof_pix) begin
                        state_d    = ST_IDLE;
                        word_cnt_d = '0;
                        done_d     = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pixel_sel = '0;
        for (int k = 0; k < PPW; k++) begin
            if (pix_idx_q == PIX_IDX_W'(k)) begin
                pixel_sel = cur_word[k*PIX_WIDTH +: PIX_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            word_cnt_q <= '0;
            pix_idx_q  <= '0;
            x_q        <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            word_cnt_q <= word_cnt_d;
            pix_idx_q  <= pix_idx_d;
            x_q        <= x_d;
            done_q     <= done_d;
        end
    end

    // Stream outputs are gated by out_valid so they read 0 whenever idle.
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = valid_int;
    assign out_pixel = valid_int ? pixel_sel : '0;
    assign out_eol   = valid_int && (x_q == LAST_X);
    assign out_eof   = valid_int && eof_pix;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fb_scanout.sv
module tb_fb_scanout;
  import fb_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int FW = 16;
  localparam int NPIX = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (1 bpp, 16 words, 16-pixel lines) ----------------
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic busy, done, out_valid, out_pixel, out_eol, out_eof;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  fb_state_e dbg_state;
  logic [DW-1:0] mem [FW];

  fb_scanout #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIX_WIDTH(1), .FRAME_WORDS(FW), .LINE_PIX(16)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_eol(out_eol), .out_eof(out_eof), .dbg_state(dbg_state)
  );
  always @(posedge clk) rd_data <= mem[rd_addr];

  // ---------------- second DUT (4 bpp, 3 words, 2-pixel lines) ----------------
  logic start4 = 1'b0;
  logic out_ready4 = 1'b1;
  logic busy4, done4, out_valid4, out_eol4, out_eof4;
  logic [3:0] out_pixel4;
  logic [1:0] rd_addr4;
  logic [7:0] rd_data4;
  fb_state_e dbg_state4;
  logic [7:0] mem4 [4];

  fb_scanout #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .PIX_WIDTH(4), .FRAME_WORDS(3), .LINE_PIX(2)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
    .rd_addr(rd_addr4), .rd_data(rd_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_pixel(out_pixel4), .out_eol(out_eol4), .out_eof(out_eof4), .dbg_state(dbg_state4)
  );
  always @(posedge clk) rd_data4 <= mem4[rd_addr4];

  initial begin
    for (int i = 0; i < FW; i++) mem[i] = DW'(i);
    mem4[0] = 8'hA5;
    mem4[1] = 8'h3C;
    mem4[2] = 8'h7E;
    mem4[3] = 8'h00;
  end

  // ---------------- checking ----------------
  int test_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard: {eof, eol, pixel} ----------------
  logic [2:0] exp_q[$];
  logic [5:0] exp4_q[$];

  int hs_cnt = 0, hs_base = 0;
  int done_cnt = 0, done_base = 0;
  int rise_cyc = 0, eof_cyc = 0, done_cyc = 0, start_cyc = 0;
  logic prev_valid = 1'b0, prev_stall = 1'b0, prev_rst = 1'b1;
  logic [2:0] prev_out = '0;
  logic [2:0] e;

  always @(negedge clk) begin
    if (prev_stall && !prev_rst)
      check("stall_hold", {out_valid, out_eof, out_eol, out_pixel}, {1'b1, prev_out});
    if (busy)
      check("rd_lead", 32'(int'(rd_addr) <= (hs_cnt - hs_base) / 8 + 2), 1);
    if (out_valid && !prev_valid) rise_cyc = cyc;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_pixel", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("pixel", {out_eof, out_eol, out_pixel}, e);
      end
      hs_cnt++;
      if (out_eof) eof_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_valid = out_valid;
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_eof, out_eol, out_pixel};
    prev_rst   = reset;
  end

  int hs4_cnt = 0, done4_cnt = 0;
  logic [5:0] e4;
  always @(negedge clk) begin
    if (out_valid4 && out_ready4) begin
      if (exp4_q.size() == 0) begin
        check("extra_pixel4", exp4_q.size(), 1);
      end else begin
        e4 = exp4_q.pop_front();
        check("pixel4", {out_eof4, out_eol4, out_pixel4}, e4);
      end
      hs4_cnt++;
    end
    if (done4) done4_cnt++;
  end

  // ---------------- ready driver ----------------
  logic rnd_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rnd_mode) out_ready = ($urandom_range(0, 9) < 3);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word n = n, 8 pixels per word LSB-first, eol every 16th, eof on the last.
  task automatic push_frame();
    int w, b;
    for (int p = 0; p < NPIX; p++) begin
      w = p / 8;
      b = p % 8;
      exp_q.push_back({(p == NPIX - 1), (p % 16 == 15), 1'((w >> b) & 1)});
    end
  endtask

  task automatic start_frame(input string tag);
    hs_base   = hs_cnt;
    done_base = done_cnt;
    start_cyc = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_start_addr"}, 32'(rd_addr), 0);
    check({tag, "_start_busy"}, 32'(busy), 1);
  endtask

  // Returns at mid-cycle of the done cycle so a start can still be issued there.
  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 1);
    check({tag, "_busy_at_done"}, 32'(busy), 0);
    @(negedge clk);
    #1;
  endtask

  task automatic frame_check(input string tag, input int rem);
    check({tag, "_count"}, hs_cnt - hs_base, NPIX);
    check({tag, "_sb_left"}, exp_q.size(), rem);
    check({tag, "_done_cnt"}, done_cnt - done_base, 1);
  endtask

  task automatic wait_hs(input string tag, input int target);
    int n;
    n = 0;
    while ((hs_cnt - hs_base) < target && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_hs_reached"}, hs_cnt - hs_base, target);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_pixel", 32'(out_pixel), 0);
    check("rst_out_eol", 32'(out_eol), 0);
    check("rst_out_eof", 32'(out_eof), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    tick();

    // Flat frame, ready always high.
    push_frame();
    out_ready = 1'b1;
    start_frame("flat");
    wait_done("flat", 400);
    frame_check("flat", 0);
    check("flat_first_valid_lat", rise_cyc - start_cyc, 3);
    check("flat_no_gaps", eof_cyc - rise_cyc, NPIX - 1);
    check("flat_done_after_eof", done_cyc - eof_cyc, 1);

    // Random backpressure, ~30% ready.
    push_frame();
    rnd_mode = 1'b1;
    start_frame("rand");
    wait_done("rand", 3000);
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    frame_check("rand", 0);

    // 4-bit pixels: A5 -> 5,A ; 3C -> C,3 ; 7E -> E,7 ; eol every 2nd.
    exp4_q.push_back({1'b0, 1'b0, 4'h5});
    exp4_q.push_back({1'b0, 1'b1, 4'hA});
    exp4_q.push_back({1'b0, 1'b0, 4'hC});
    exp4_q.push_back({1'b0, 1'b1, 4'h3});
    exp4_q.push_back({1'b0, 1'b0, 4'hE});
    exp4_q.push_back({1'b1, 1'b1, 4'h7});
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("pix4_start_addr", 32'(rd_addr4), 0);
    n = 0;
    while (!done4 && n < 100) begin
      tick();
      n++;
    end
    check("pix4_done_seen", 32'(done4), 1);
    @(negedge clk);
    #1;
    check("pix4_count", hs4_cnt, 6);
    check("pix4_sb_left", exp4_q.size(), 0);
    check("pix4_done_cnt", done4_cnt, 1);

    // Start pulsed mid-frame is ignored; start in the done cycle is accepted.
    push_frame();
    push_frame();
    start_frame("mid");
    wait_hs("mid", 40);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("mid", 400);
    frame_check("mid", NPIX);
    start_frame("b2b");
    wait_done("b2b", 400);
    frame_check("b2b", 0);
    check("b2b_first_valid_lat", rise_cyc - start_cyc, 3);

    // Reset while stalled at pixel 50, then a clean replay.
    push_frame();
    start_frame("rstmid");
    wait_hs("rstmid", 50);
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_done", 32'(done), 0);
    check("rstmid_rd_addr", 32'(rd_addr), 0);
    check("rstmid_outs", {out_valid, out_pixel, out_eol, out_eof}, 0);
    check("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (4) tick();
    check("rstmid_stays_idle", {busy, out_valid}, 0);
    exp_q.delete();
    push_frame();
    out_ready = 1'b1;
    start_frame("replay");
    wait_done("replay", 400);
    frame_check("replay", 0);

    // Final pixel stalled for 10 cycles.
    push_frame();
    start_frame("eofstall");
    wait_hs("eofstall", NPIX - 1);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("eofstall_hold", {out_valid, out_eof, busy, done}, 4'b1110);
    end
    out_ready = 1'b1;
    wait_done("eofstall", 20);
    frame_check("eofstall", 0);
    repeat (3) tick();
    check("eofstall_done_once", done_cnt - done_base, 1);

    $display("[TB] %0d tests run, %0d failed", test_cnt, err_cnt);
    $finish;
  end

endmodule
